// File: rtl/lsu_align_bridge_if.sv
// ---------------------------------------------------------------------------
// Upstream load/store channels between the EXU load/store handler and
// lsu_align_bridge.
//
// lsu_ldst_req_if : request channel
//   vld        request valid (driven by the master)
//   rdy        request ready (driven by the slave)
//   pkt.addr   byte address
//   pkt.st     1 = store, 0 = load
//   pkt.data   store data, LSB-justified
//   pkt.strobe 0001 / 0011 / 1111, LSB-justified
//
// lsu_ldst_rsp_if : response channel
//   vld        response valid (driven by the master)
//   rdy        response ready (driven by the slave)
//   pkt.data   load data, LSB-justified, upper bytes zero (0 for stores)
// ---------------------------------------------------------------------------
interface lsu_ldst_req_if;
  typedef struct packed {
    logic [31:0] addr;
    logic        st;
    logic [31:0] data;
    logic [3:0]  strobe;
  } pkt_t;

  logic vld;
  logic rdy;
  pkt_t pkt;

  modport mst (output vld, output pkt, input rdy);
  modport slv (input vld, input pkt, output rdy);
endinterface

interface lsu_ldst_rsp_if;
  typedef struct packed {
    logic [31:0] data;
  } pkt_t;

  logic vld;
  logic rdy;
  pkt_t pkt;

  modport mst (output vld, output pkt, input rdy);
  modport slv (input vld, input pkt, output rdy);
endinterface

// File: rtl/lsu_align_bridge.sv
// ---------------------------------------------------------------------------
// lsu_align_bridge
//
// Converts raw byte-address load/store requests from the EXU load/store
// handler into word-aligned 32-bit bus transactions. Store data and strobes
// are shifted onto the addressed byte lanes; load data is shifted back to
// bit 0 and masked to the access size. One transaction is in flight at a time.
//
// Optional feature macro: LSU_MISALIGN_SPLIT_EN
//   defined   : misaligned accesses are split into two word beats and merged
//   undefined : misaligned accesses are answered with data 0, no bus traffic,
//               and a one-cycle misalign_err pulse
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   ldst_req_slv       upstream request channel (slave side)
//   ldst_rsp_mst       upstream response channel (master side)
//   bus_req_*          word-aligned bus request (vld/rdy, addr, wr, wdata, wstrb)
//   bus_rsp_*          bus read response (vld/rdy, rdata)
//   misalign_err       one-cycle pulse after a dropped misaligned access
// ---------------------------------------------------------------------------
module lsu_align_bridge #(
  parameter int XLEN = 32,
  parameter int SB_W = XLEN / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  lsu_ldst_req_if.slv       ldst_req_slv,
  lsu_ldst_rsp_if.mst       ldst_rsp_mst,
  output logic              bus_req_vld,
  input  logic              bus_req_rdy,
  output logic [XLEN-1:0]   bus_req_addr,
  output logic              bus_req_wr,
  output logic [XLEN-1:0]   bus_req_wdata,
  output logic [SB_W-1:0]   bus_req_wstrb,
  input  logic              bus_rsp_vld,
  output logic              bus_rsp_rdy,
  input  logic [XLEN-1:0]   bus_rsp_rdata,
  output logic              misalign_err
);

`ifdef LSU_MISALIGN_SPLIT_EN
  typedef enum logic [2:0] {IDLE, BREQ, BRSP, URSP, BREQ2, BRSP2} state_t;
`else
  typedef enum logic [2:0] {IDLE, BREQ, BRSP, URSP} state_t;
`endif

  state_t state_reg, state_next;

  // Incoming request decode
  logic            accept;
  logic [1:0]      off_in;
  logic [4:0]      shift_in;
  logic [SB_W-1:0] strobe_in;
  logic            mis_in;

  assign accept    = (state_reg == IDLE) && ldst_req_slv.vld;
  assign off_in    = ldst_req_slv.pkt.addr[1:0];
  assign shift_in  = {off_in, 3'b000};
  assign strobe_in = ldst_req_slv.pkt.strobe;
  // A halfword at offset 3 or a word at any nonzero offset crosses a word.
  assign mis_in    = ((strobe_in == 4'b0011) && (off_in == 2'd3)) ||
                     ((strobe_in == 4'b1111) && (off_in != 2'd0));

  // Captured transaction context (not reset)
  logic            st_reg;
  logic [1:0]      off_reg;
  logic [SB_W-1:0] strobe_reg;
  logic [XLEN-1:0] bus_addr_reg;
  logic            bus_wr_reg;
  logic [XLEN-1:0] bus_wdata_reg;
  logic [SB_W-1:0] bus_wstrb_reg;
  logic [XLEN-1:0] rsp_data_reg;
  logic            misalign_err_reg;

  logic [4:0]      shift_amt;
  logic [XLEN-1:0] byte_mask;
  logic [XLEN-1:0] load_aligned;

  assign shift_amt = {off_reg, 3'b000};

  // Expand the LSB-justified strobe into a bit mask for the returned data.
  for (genvar gi = 0; gi < SB_W; gi++) begin : g_mask
    assign byte_mask[gi*8 +: 8] = {8{strobe_reg[gi]}};
  end

  assign load_aligned = (bus_rsp_rdata >> shift_amt) & byte_mask;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [XLEN-1:0] data_reg;
  logic [XLEN-3:0] next_word_reg;
  logic            mis_reg;
  logic [XLEN-1:0] lo_reg;
  logic [5:0]      hi_shift;
  logic [XLEN-1:0] load_merged;

  // Second beat carries the bytes that spilled past the first word.
  assign hi_shift    = 6'd32 - {1'b0, shift_amt};
  assign load_merged = ((lo_reg >> shift_amt) | (bus_rsp_rdata << hi_shift)) & byte_mask;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      misalign_err_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
`ifdef LSU_MISALIGN_SPLIT_EN
      misalign_err_reg <= 1'b0;
`else
      misalign_err_reg <= accept && mis_in;
`endif
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next       = state_reg;
    ldst_req_slv.rdy = 1'b0;
    ldst_rsp_mst.vld = 1'b0;
    bus_req_vld      = 1'b0;
    bus_rsp_rdy      = 1'b0;
    case (state_reg)
      IDLE: begin
        ldst_req_slv.rdy = 1'b1;
        if (ldst_req_slv.vld) begin
`ifdef LSU_MISALIGN_SPLIT_EN
          state_next = BREQ;
`else
          state_next = mis_in ? URSP : BREQ;
`endif
        end
      end
      BREQ: begin
        bus_req_vld = 1'b1;
        if (bus_req_rdy) state_next = BRSP;
      end
      BRSP: begin
        bus_rsp_rdy = 1'b1;
        if (bus_rsp_vld) begin
`ifdef LSU_MISALIGN_SPLIT_EN
          state_next = mis_reg ? BREQ2 : URSP;
`else
          state_next = URSP;
`endif
        end
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      BREQ2: begin
        bus_req_vld = 1'b1;
        if (bus_req_rdy) state_next = BRSP2;
      end
      BRSP2: begin
        bus_rsp_rdy = 1'b1;
        if (bus_rsp_vld) state_next = URSP;
      end
`endif
      URSP: begin
        ldst_rsp_mst.vld = 1'b1;
        if (ldst_rsp_mst.rdy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: bus request fields are registered so they stay put while the
  // bus stalls; response data is latched once per transaction.
  always_ff @(posedge clk) begin
    if (accept) begin
      st_reg        <= ldst_req_slv.pkt.st;
      off_reg       <= off_in;
      strobe_reg    <= strobe_in;
      bus_addr_reg  <= {ldst_req_slv.pkt.addr[XLEN-1:2], 2'b00};
      bus_wr_reg    <= ldst_req_slv.pkt.st;
      bus_wstrb_reg <= strobe_in << off_in;
      bus_wdata_reg <= ldst_req_slv.pkt.data << shift_in;
      // Stores and dropped misaligned accesses answer with zero.
      rsp_data_reg  <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      data_reg      <= ldst_req_slv.pkt.data;
      next_word_reg <= ldst_req_slv.pkt.addr[XLEN-1:2] + (XLEN-2)'(1);
      mis_reg       <= mis_in;
`endif
    end

    if ((state_reg == BRSP) && bus_rsp_vld) begin
`ifdef LSU_MISALIGN_SPLIT_EN
      if (mis_reg) begin
        lo_reg        <= bus_rsp_rdata;
        bus_addr_reg  <= {next_word_reg, 2'b00};
        bus_wstrb_reg <= strobe_reg >> (3'd4 - {1'b0, off_reg});
        bus_wdata_reg <= data_reg >> hi_shift;
      end else begin
        rsp_data_reg  <= st_reg ? '0 : load_aligned;
      end
`else
      rsp_data_reg <= st_reg ? '0 : load_aligned;
`endif
    end

`ifdef LSU_MISALIGN_SPLIT_EN
    if ((state_reg == BRSP2) && bus_rsp_vld) begin
      rsp_data_reg <= st_reg ? '0 : load_merged;
    end
`endif
  end

  assign bus_req_addr          = bus_addr_reg;
  assign bus_req_wr            = bus_wr_reg;
  assign bus_req_wdata         = bus_wdata_reg;
  assign bus_req_wstrb         = bus_wstrb_reg;
  assign ldst_rsp_mst.pkt.data = rsp_data_reg;
  assign misalign_err          = misalign_err_reg;

endmodule
